pipe_alu_unit: RTL and testbench
================================

Name: pipe_alu_unit

Overview:
- Parametrised two-stage pipelined ALU with registered flag state and condition-code evaluation.
- Generalises the fixed 16-bit ALU / ccgen / flag-register path. Adds:
  - configurable width;
  - valid/ready handshake with backpressure;
  - pipeline flush;
  - per-operation condition result.
- Sits between register-read and writeback/branch resolution in the core datapath.

Parameters:
- WIDTH, 16, data path width in bits (minimum 4).
- CCW, 4, width of condition-select field.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  unit accepts the operation this cycle
- op  input  3  ALU function select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- setflag  input  1  operation updates the flag register
- ccsel  input  CCW  condition to evaluate for this operation
- flush  input  1  discard all in-flight operations
- out_valid  output  1  stage-2 result valid
- out_ready  input  1  downstream consumes the result
- result  output  WIDTH  ALU result
- carry  output  1  carry out of bit WIDTH-1 for this result
- cc_true  output  1  evaluated condition for this operation
- flags  output  4  current flag register

Behaviour:
- Reset: clk and reset are decided as stated under Ports: reset is synchronous and active-high; clk is the clock. On reset, all of the following clear to 0:
  - s1_valid, s2_valid;
  - stage-1 operand registers;
  - result, carry, cc_true, flags.
- Stage 1 (S1): registers op, a, b, setflag, ccsel.
- Stage 2 (S2): registers the computed result, carry and cc_true.
- Advance enables:
  - e2 = ~s2_valid | out_ready;
  - e1 = ~s1_valid | e2.
- Handshake:
  - in_ready = e1 & ~flush.
  - An input is accepted when in_valid & in_ready.
  - in_ready is not allowed to depend combinationally on in_valid.
- Latency and throughput:
  - With out_ready held at 1, out_valid rises 2 cycles after acceptance.
  - Throughput is 1 operation per cycle.
- Backpressure:
  - While out_valid=1 and out_ready=0, result, carry and cc_true hold stable.
  - The S1 entry is held, so at most 2 operations are in flight.
- Op encoding:
  - 0 = zero
  - 1 = a
  - 2 = a+b
  - 3 = -a (two's complement)
  - 4 = a|b
  - 5 = ~a
  - 6 = a+1
  - 7 = a-1
  - All results are truncated to WIDTH bits.
- Carry:
  - carry = carry out of bit WIDTH-1, for ops 2 and 6 only; 0 for all other ops.
  - carry2 = carry out of bit WIDTH-2 (the sum of the low WIDTH-1 bits), for ops 2 and 6 only; 0 for all other ops.
- Flag bits: [0] carry, [1] carry2, [2] zero (result==0), [3] sign (result[WIDTH-1]).
- Flag update: on the S1->S2 transfer of an entry with setflag=1, flags is loaded from that entry's values. Entries with setflag=0 leave flags unchanged.
- cc_true:
  - Evaluated at the S1->S2 transfer, against the flags value before that entry's own update. It therefore reflects all older flag-setting operations.
  - ccsel encoding:
    - 0 = 1
    - 1 = f0, 2 = ~f0
    - 3 = f1, 4 = ~f1
    - 5 = f2, 6 = ~f2
    - 7 = f3, 8 = ~f3
    - 9..15 = 1
- Flush:
  - At the next edge, s1_valid and s2_valid clear to 0; result, carry and cc_true hold their old values.
  - An input presented during a flush cycle is not accepted.
  - Flag updates already committed by the flushed entries remain. The S1 entry never commits, because no transfer occurs.
- Simultaneous flush and out_ready: the flush wins; out_valid is 0 on the next cycle. The downstream consumption in the current cycle still counts.
- Reset mid-operation: all in-flight entries are lost; outputs return to their reset values on the next edge.
- Wrap-around: 0xFFFF+1 gives 0x0000 with carry=1. a-1 with a=0 gives all-ones with carry=0.

Decomposition:
- Shared package pipe_alu_pkg holds:
  - op code constants (OP_ZERO .. OP_DEC);
  - cc select constants (CC_ALWAYS, CC_C, CC_NC, ..., CC_NS);
  - flag bit indices (FLG_C, FLG_C2, FLG_Z, FLG_S).
- One sub-module: alu_core, a combinational block parametrised by WIDTH. Inputs: op, a, b. Outputs: result, carry, carry2.
- Condition evaluation and the pipeline control stay in the top level.

Test Plan:
- WIDTH=16; a=0xFFFF, b=0x0001, op=2, setflag=1, out_ready=1 -> 2 cycles later: out_valid=1, result=0x0000, carry=1, flags=4'b0111.
- Op 1 with a=0, setflag=1, then op 1 with ccsel=5 and ccsel=6 (setflag=0) -> second result cc_true=1, third result cc_true=0; flags stays 4'b0100.
- out_ready=0, in_valid streaming ops A,B,C -> A and B accepted, in_ready=0 for C, result=A held stable. Raise out_ready -> A, B, C delivered in order, with no duplicates or drops.
- Two ops in flight; assert flush for one cycle with in_valid=1 -> the next cycle has out_valid=0, the flush-cycle input is not accepted, and flags reflects only the S1->S2 transfers that happened before the flush edge.
- Reset asserted with 2 ops in flight -> the next cycle has out_valid=0, flags=0, result=0, in_ready=1.
- WIDTH=8; a=0x7F, b=0x01, op=2, setflag=1 -> result=0x80, carry=0, flags=4'b1010. Then op=7 with a=0x00 -> result=0xFF, carry=0.

Source files
------------

// File: rtl/pipe_alu_pkg.sv
// Shared definitions for the pipelined ALU slice.
// Contents: op code enumeration, condition-select codes, flag bit indices.
package pipe_alu_pkg;

    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_PASS = 3'd1,
        OP_ADD  = 3'd2,
        OP_NEG  = 3'd3,
        OP_OR   = 3'd4,
        OP_NOT  = 3'd5,
        OP_INC  = 3'd6,
        OP_DEC  = 3'd7
    } op_e;

    // Condition-select codes; anything above CC_NS evaluates true.
    localparam int CC_ALWAYS = 0;
    localparam int CC_C      = 1;
    localparam int CC_NC     = 2;
    localparam int CC_C2     = 3;
    localparam int CC_NC2    = 4;
    localparam int CC_Z      = 5;
    localparam int CC_NZ     = 6;
    localparam int CC_S      = 7;
    localparam int CC_NS     = 8;

    // Flag register bit positions.
    localparam int FLG_C  = 0;
    localparam int FLG_C2 = 1;
    localparam int FLG_Z  = 2;
    localparam int FLG_S  = 3;

endpackage

// File: rtl/pipe_alu_unit_if.sv
// Handshake/data bundle between register-read, the pipelined ALU and
// writeback/branch resolution.
// master: upstream + downstream side (drives operation, flush, out_ready).
// slave : the ALU unit (drives in_ready, result, carry, cc_true, flags).
interface pipe_alu_unit_if #(
    parameter int WIDTH = 16,
    parameter int CCW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             setflag;
    logic [CCW-1:0]   ccsel;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             cc_true;
    logic [3:0]       flags;

    modport master (
        output in_valid, op, a, b, setflag, ccsel, flush, out_ready,
        input  in_ready, out_valid, result, carry, cc_true, flags
    );

    modport slave (
        input  in_valid, op, a, b, setflag, ccsel, flush, out_ready,
        output in_ready, out_valid, result, carry, cc_true, flags
    );
endinterface

// File: rtl/pipe_alu_unit_alu_core.sv
// Combinational ALU datapath.
// Inputs : op (function select), a, b (operands).
// Outputs: result (truncated to WIDTH), carry (out of bit WIDTH-1),
//          carry2 (out of bit WIDTH-2); both carries only for add/increment.
module alu_core
    import pipe_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             carry2
);
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] low_sum;

    always_comb begin
        // Increment shares the adder with b forced to one.
        addend  = (op_e'(op) == OP_INC) ? WIDTH'(1) : b;
        sum     = {1'b0, a} + {1'b0, addend};
        // Sum of the low WIDTH-1 bits; its top bit is the carry into the sign bit.
        low_sum = {1'b0, a[WIDTH-2:0]} + {1'b0, addend[WIDTH-2:0]};
        result  = '0;
        carry   = 1'b0;
        carry2  = 1'b0;
        case (op_e'(op))
            OP_ZERO: result = '0;
            OP_PASS: result = a;
            OP_ADD, OP_INC: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                carry2 = low_sum[WIDTH-1];
            end
            OP_NEG:  result = ~a + WIDTH'(1);
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            OP_DEC:  result = a - WIDTH'(1);
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/pipe_alu_unit.sv
// Two-stage pipelined ALU with flag register and condition evaluation.
// Ports: clk, reset (synchronous, active-high), bus (slave side of
// pipe_alu_unit_if: in_valid/in_ready/op/a/b/setflag/ccsel/flush in,
// out_valid/out_ready/result/carry/cc_true/flags out).
// Stage 1 holds the operation; stage 2 holds the computed result. Flags
// and the condition are resolved on the stage-1 to stage-2 transfer.
module pipe_alu_unit
    import pipe_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CCW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    pipe_alu_unit_if.slave bus
);
    logic [2:0]       op_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic             setflag_p1;
    logic [CCW-1:0]   ccsel_p1;
    logic             vld_p1;

    logic [WIDTH-1:0] result_p2;
    logic             carry_p2;
    logic             cc_p2;
    logic             vld_p2;
    logic [3:0]       flags_q;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_carry2;
    logic [3:0]       new_flags;
    logic             e1;
    logic             e2;

    function automatic logic cc_eval(input logic [CCW-1:0] sel, input logic [3:0] f);
        case (int'(sel))
            CC_C:    return f[FLG_C];
            CC_NC:   return ~f[FLG_C];
            CC_C2:   return f[FLG_C2];
            CC_NC2:  return ~f[FLG_C2];
            CC_Z:    return f[FLG_Z];
            CC_NZ:   return ~f[FLG_Z];
            CC_S:    return f[FLG_S];
            CC_NS:   return ~f[FLG_S];
            default: return 1'b1;
        endcase
    endfunction

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op     (op_p1),
        .a      (a_p1),
        .b      (b_p1),
        .result (alu_result),
        .carry  (alu_carry),
        .carry2 (alu_carry2)
    );

    always_comb begin
        new_flags         = '0;
        new_flags[FLG_C]  = alu_carry;
        new_flags[FLG_C2] = alu_carry2;
        new_flags[FLG_Z]  = (alu_result == '0);
        new_flags[FLG_S]  = alu_result[WIDTH-1];
    end

    // A stage may advance when it is empty or the stage after it drains.
    assign e2 = ~vld_p2 | bus.out_ready;
    assign e1 = ~vld_p1 | e2;
    assign bus.in_ready = e1 & ~bus.flush;

    // Stage 1: capture the operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            op_p1      <= '0;
            a_p1       <= '0;
            b_p1       <= '0;
            setflag_p1 <= 1'b0;
            ccsel_p1   <= '0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (e1) begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                op_p1      <= bus.op;
                a_p1       <= bus.a;
                b_p1       <= bus.b;
                setflag_p1 <= bus.setflag;
                ccsel_p1   <= bus.ccsel;
            end
        end
    end

    // Stage 2: capture result, resolve condition against the flags as they
    // stood before this entry, then commit this entry's flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            carry_p2  <= 1'b0;
            cc_p2     <= 1'b0;
            flags_q   <= '0;
        end else if (bus.flush) begin
            vld_p2 <= 1'b0;
        end else if (e2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result_p2 <= alu_result;
                carry_p2  <= alu_carry;
                cc_p2     <= cc_eval(ccsel_p1, flags_q);
                if (setflag_p1) begin
                    flags_q <= new_flags;
                end
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.result    = result_p2;
    assign bus.carry     = carry_p2;
    assign bus.cc_true   = cc_p2;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_pipe_alu_unit.sv
module tb_pipe_alu_unit;
    import pipe_alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_alu_unit_if #(.WIDTH(16), .CCW(4)) bus ();
    pipe_alu_unit_if #(.WIDTH(8),  .CCW(4)) bus8 ();

    pipe_alu_unit #(.WIDTH(16), .CCW(4)) dut  (.clk(clk), .reset(reset), .bus(bus));
    pipe_alu_unit #(.WIDTH(8),  .CCW(4)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        setflag;
        logic [3:0]  ccsel;
    } in_rec_t;

    typedef struct {
        logic [15:0] result;
        logic        carry;
        logic        cc;
        logic [3:0]  flags;
    } out_rec_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        sf;
        logic [3:0]  cc;
        logic [15:0] r;
        logic        c;
        logic        t;
        logic [3:0]  f;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int stable_errs = 0;
    in_rec_t  acc_q[$];
    out_rec_t got_q[$];
    logic        hold_pend = 1'b0;
    logic [15:0] hold_result;
    logic        hold_carry;
    logic        hold_cc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Passive observer of handshakes and of output stability under backpressure.
    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready)
            acc_q.push_back('{op: bus.op, a: bus.a, b: bus.b, setflag: bus.setflag, ccsel: bus.ccsel});
        if (bus.out_valid && bus.out_ready)
            got_q.push_back('{result: bus.result, carry: bus.carry, cc: bus.cc_true, flags: bus.flags});
        if (hold_pend && bus.out_valid &&
            (bus.result !== hold_result || bus.carry !== hold_carry || bus.cc_true !== hold_cc))
            stable_errs <= stable_errs + 1;
        hold_pend   <= bus.out_valid && !bus.out_ready && !reset && !bus.flush;
        hold_result <= bus.result;
        hold_carry  <= bus.carry;
        hold_cc     <= bus.cc_true;
    end

    // Reference: apply one operation to the architectural flag state.
    function automatic out_rec_t ref_op(input in_rec_t x, inout logic [3:0] fl);
        int ua, ub, s, res, c, c2;
        logic t;
        out_rec_t r;
        ua = int'(x.a);
        ub = int'(x.b);
        c = 0;
        c2 = 0;
        res = 0;
        case (x.op)
            3'd0: res = 0;
            3'd1: res = ua;
            3'd2, 3'd6: begin
                if (x.op == 3'd6) ub = 1;
                s   = ua + ub;
                res = s % 65536;
                c   = s / 65536;
                c2  = ((ua % 32768) + (ub % 32768)) / 32768;
            end
            3'd3: res = (65536 - ua) % 65536;
            3'd4: res = ua | ub;
            3'd5: res = 65535 - ua;
            default: res = (ua + 65535) % 65536;
        endcase
        case (x.ccsel)
            4'd1: t = fl[0];
            4'd2: t = !fl[0];
            4'd3: t = fl[1];
            4'd4: t = !fl[1];
            4'd5: t = fl[2];
            4'd6: t = !fl[2];
            4'd7: t = fl[3];
            4'd8: t = !fl[3];
            default: t = 1'b1;
        endcase
        if (x.setflag)
            fl = {res >= 32768, res == 0, c2 != 0, c != 0};
        r.result = res[15:0];
        r.carry  = (c != 0);
        r.cc     = t;
        r.flags  = fl;
        return r;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic sf, input logic [3:0] cc);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.setflag = sf;
        bus.ccsel = cc;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{3'd2, 16'hFFFF, 16'h0001, 1'b1, 4'd0, 16'h0000, 1'b1, 1'b1, 4'b0111};
        tbl[1]  = '{3'd1, 16'h0000, 16'h0000, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b1, 4'b0100};
        tbl[2]  = '{3'd1, 16'h1234, 16'h0000, 1'b0, 4'd5, 16'h1234, 1'b0, 1'b1, 4'b0100};
        tbl[3]  = '{3'd1, 16'h1234, 16'h0000, 1'b0, 4'd6, 16'h1234, 1'b0, 1'b0, 4'b0100};
        tbl[4]  = '{3'd7, 16'h0000, 16'h0000, 1'b1, 4'd1, 16'hFFFF, 1'b0, 1'b0, 4'b1000};
        tbl[5]  = '{3'd3, 16'h0001, 16'h0000, 1'b0, 4'd7, 16'hFFFF, 1'b0, 1'b1, 4'b1000};
        tbl[6]  = '{3'd6, 16'hFFFF, 16'h0000, 1'b1, 4'd8, 16'h0000, 1'b1, 1'b0, 4'b0111};
        tbl[7]  = '{3'd4, 16'hF0F0, 16'h0F01, 1'b1, 4'd3, 16'hFFF1, 1'b0, 1'b1, 4'b1000};
        tbl[8]  = '{3'd5, 16'h00FF, 16'h0000, 1'b1, 4'd2, 16'hFF00, 1'b0, 1'b1, 4'b1000};
        tbl[9]  = '{3'd0, 16'h1234, 16'h5678, 1'b1, 4'd4, 16'h0000, 1'b0, 1'b1, 4'b0100};
        tbl[10] = '{3'd2, 16'h4000, 16'h4000, 1'b1, 4'd9, 16'h8000, 1'b0, 1'b1, 4'b1010};
        tbl[11] = '{3'd2, 16'h8000, 16'h8000, 1'b0, 4'd15, 16'h0000, 1'b1, 1'b1, 4'b1010};

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.setflag = 1'b0; bus.ccsel = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0;
        bus8.setflag = 1'b0; bus8.ccsel = '0; bus8.flush = 1'b0; bus8.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_carry",     32'(bus.carry),     32'd0);
        check("rst_cc_true",   32'(bus.cc_true),   32'd0);
        check("rst_flags",     32'(bus.flags),     32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst8_result",   32'(bus8.result),   32'd0);

        // Table vectors, one operation at a time with latency check.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sf, tbl[i].cc);
            @(negedge clk);
            check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1 bus.in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_early_valid", i), 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("v%0d_result", i),    32'(bus.result),    32'(tbl[i].r));
            check($sformatf("v%0d_carry", i),     32'(bus.carry),     32'(tbl[i].c));
            check($sformatf("v%0d_cc_true", i),   32'(bus.cc_true),   32'(tbl[i].t));
            check($sformatf("v%0d_flags", i),     32'(bus.flags),     32'(tbl[i].f));
        end

        // Backpressure: A and B fill the pipe, C waits, then all drain in order.
        @(posedge clk); #1;
        got_q.delete();
        bus.out_ready = 1'b0;
        drive(3'd1, 16'hAAAA, 16'h0000, 1'b0, 4'd0);
        @(posedge clk); #1 drive(3'd2, 16'h0001, 16'h0002, 1'b0, 4'd0);
        @(posedge clk); #1 drive(3'd5, 16'h00FF, 16'h0000, 1'b0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready),  32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result_hold", 32'(bus.result), 32'h0000AAAA);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("bp_order0", 32'(got_q[0].result), 32'h0000AAAA);
            check("bp_order1", 32'(got_q[1].result), 32'h00000003);
            check("bp_order2", 32'(got_q[2].result), 32'h0000FF00);
        end

        // Flush with two in flight: only the stage-2 entry's flags remain.
        pulse_reset();
        got_q.delete();
        acc_q.delete();
        bus.out_ready = 1'b0;
        drive(3'd1, 16'h8001, 16'h0000, 1'b1, 4'd0);
        @(posedge clk); #1 drive(3'd1, 16'h0000, 16'h0000, 1'b1, 4'd0);
        @(posedge clk); #1 drive(3'd2, 16'h0005, 16'h0005, 1'b1, 4'd0);
        bus.flush = 1'b1;
        @(negedge clk);
        check("fl_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1 bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", 32'(bus.out_valid), 32'd0);
        check("fl_flags",     32'(bus.flags),     32'b1000);
        check("fl_result",    32'(bus.result),    32'h00008001);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("fl_no_output", 32'(got_q.size()), 32'd0);
        check("fl_accepted",  32'(acc_q.size()), 32'd2);
        check("fl_flags_after", 32'(bus.flags),  32'b1000);

        // Reset with two in flight.
        pulse_reset();
        bus.out_ready = 1'b0;
        drive(3'd1, 16'h8000, 16'h0000, 1'b1, 4'd0);
        @(posedge clk); #1 drive(3'd1, 16'h0123, 16'h0000, 1'b1, 4'd0);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        check("mr_flags_before", 32'(bus.flags), 32'b1000);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check("mr_flags",     32'(bus.flags),     32'd0);
        check("mr_result",    32'(bus.result),    32'd0);
        check("mr_in_ready",  32'(bus.in_ready),  32'd1);

        // Randomised traffic against the reference model.
        pulse_reset();
        @(negedge clk);
        got_q.delete();
        acc_q.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.op        = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: bus.a = 16'hFFFF;
                1: bus.a = 16'h0000;
                2: bus.a = 16'h7FFF;
                default: bus.a = 16'($urandom);
            endcase
            bus.b         = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
            bus.setflag   = 1'($urandom_range(0, 1));
            bus.ccsel     = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rand_count", 32'(got_q.size()), 32'(acc_q.size()));
        begin
            logic [3:0] fl;
            out_rec_t e;
            fl = 4'b0000;
            for (int i = 0; i < acc_q.size() && i < got_q.size(); i++) begin
                e = ref_op(acc_q[i], fl);
                check($sformatf("rand%0d_result", i), 32'(got_q[i].result), 32'(e.result));
                check($sformatf("rand%0d_carry", i),  32'(got_q[i].carry),  32'(e.carry));
                check($sformatf("rand%0d_cc", i),     32'(got_q[i].cc),     32'(e.cc));
                check($sformatf("rand%0d_flags", i),  32'(got_q[i].flags),  32'(e.flags));
            end
        end
        check("hold_stable", 32'(stable_errs), 32'd0);

        // Narrow instance: sign and carry2 positions move with WIDTH.
        @(posedge clk); #1;
        bus8.in_valid = 1'b1; bus8.op = 3'd2; bus8.a = 8'h7F; bus8.b = 8'h01;
        bus8.setflag = 1'b1; bus8.ccsel = 4'd0;
        @(posedge clk); #1 bus8.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("w8_add_valid",  32'(bus8.out_valid), 32'd1);
        check("w8_add_result", 32'(bus8.result),    32'h80);
        check("w8_add_carry",  32'(bus8.carry),     32'd0);
        check("w8_add_flags",  32'(bus8.flags),     32'b1010);
        @(posedge clk); #1;
        bus8.in_valid = 1'b1; bus8.op = 3'd7; bus8.a = 8'h00; bus8.b = 8'h00;
        bus8.setflag = 1'b0; bus8.ccsel = 4'd0;
        @(posedge clk); #1 bus8.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("w8_dec_result", 32'(bus8.result), 32'hFF);
        check("w8_dec_carry",  32'(bus8.carry),  32'd0);
        check("w8_dec_flags",  32'(bus8.flags),  32'b1010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
